// File: rtl/sync_fifo_flagged_pkg.sv
// Shared types and helpers for the flagged synchronous FIFO.
// Optional parity storage is enabled by defining SYNC_FIFO_PARITY_EN.
package sync_fifo_pkg;

    // Which sides of the FIFO accept a transfer this cycle: {write, read}
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        BOTH  = 2'b11
    } access_mode_t;

    // Widest word the parity helper accepts; narrower words are zero-extended
    localparam int PARITY_MAX_W = 1024;

    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction

    // Even parity: the returned bit makes the total number of ones even
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_fifo_flagged_if.sv
// Request/status bundle between a FIFO user (master) and the FIFO (slave).
// parity_err_o exists only when SYNC_FIFO_PARITY_EN is defined.
interface sync_fifo_flagged_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  flush_i;
    logic                  write_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  read_i;
    logic                  clear_err_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic                  full_o;
    logic                  empty_o;
    logic                  almost_full_o;
    logic                  almost_empty_o;
    logic [CW-1:0]         count_o;
    logic                  overflow_o;
    logic                  underflow_o;
`ifdef SYNC_FIFO_PARITY_EN
    logic                  parity_err_o;
`endif

    modport master (
        output flush_i, write_i, wr_data_i, read_i, clear_err_i,
        input  rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, overflow_o, underflow_o
`ifdef SYNC_FIFO_PARITY_EN
        , input parity_err_o
`endif
    );

    modport slave (
        input  flush_i, write_i, wr_data_i, read_i, clear_err_i,
        output rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, overflow_o, underflow_o
`ifdef SYNC_FIFO_PARITY_EN
        , output parity_err_o
`endif
    );

endinterface

// File: rtl/sync_fifo_flagged_mem.sv
// Storage array for the flagged FIFO: one write port, one read port that is
// combinational (FWFT) or registered. The array itself is never reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int FWFT       = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                we_i,
    input  logic [addr_bits(FIFO_DEPTH)-1:0]    waddr_i,
    input  logic [DATA_WIDTH-1:0]               wdata_i,
    input  logic                                re_i,
    input  logic [addr_bits(FIFO_DEPTH)-1:0]    raddr_i,
    output logic [DATA_WIDTH-1:0]               rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    if (FWFT != 0) begin : g_comb_rd
        // Head word is visible without a read strobe; strobe and reset have no role here
        logic unused_rd_ctl;
        assign unused_rd_ctl = re_i & rst_n_i;
        assign rdata_o = mem_q[raddr_i];
    end else begin : g_reg_rd
        logic [DATA_WIDTH-1:0] rdata_q;

        // Registered read: capture the addressed word on an accepted read, else hold
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                rdata_q <= '0;
            end else if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end

        assign rdata_o = rdata_q;
    end

endmodule

// File: rtl/sync_fifo_flagged.sv
// Flagged synchronous FIFO: pointers with wrap bit, occupancy counter,
// registered full/empty/almost flags, sticky overflow/underflow, flush.
// Define SYNC_FIFO_PARITY_EN to store and check an even-parity bit per word.
module sync_fifo_flagged
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int FWFT       = 1,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    sync_fifo_flagged_if.slave bus
);

    localparam int AW = addr_bits(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef SYNC_FIFO_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif
    localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          afull_q, afull_d, aempty_q, aempty_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          rd_en, wr_en;
    access_mode_t  mode;
    logic [MW-1:0] mem_wdata, mem_rdata;

    // Flush blocks both sides so the storage is not touched that cycle
    assign rd_en = bus.read_i & ~empty_q & ~bus.flush_i;
    assign wr_en = bus.write_i & (~full_q | rd_en) & ~bus.flush_i;

    // Next pointers, occupancy, flags and sticky errors
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mode     = access_mode_t'({wr_en, rd_en});

        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (mode)
                WRITE: begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                end
                READ: begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                end
                BOTH: begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                default: ;
            endcase
        end

        full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        afull_d  = (count_d >= AF_C);
        aempty_d = (count_d <= AE_C);

        ovf_d = ovf_q;
        udf_d = udf_q;
        if (bus.clear_err_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else if (!bus.flush_i) begin
            if (bus.write_i && !wr_en) ovf_d = 1'b1;
            if (bus.read_i && empty_q) udf_d = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    assign mem_wdata = {even_parity(PARITY_MAX_W'(bus.wr_data_i)), bus.wr_data_i};
`else
    assign mem_wdata = bus.wr_data_i;
`endif

    sync_fifo_mem #(
        .DATA_WIDTH (MW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FWFT       (FWFT)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (mem_wdata),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    // Word on the output is valid: FWFT when a read is accepted, registered mode the cycle after
    logic rd_chk;

    if (FWFT != 0) begin : g_fwft_valid
        assign bus.rd_valid_o = ~empty_q;
        assign rd_chk         = rd_en;
    end else begin : g_reg_valid
        logic rd_valid_q;

        // One-cycle pulse accompanying the registered read data
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_en;
            end
        end

        assign bus.rd_valid_o = rd_valid_q;
        assign rd_chk         = rd_valid_q;
    end

`ifdef SYNC_FIFO_PARITY_EN
    logic perr_q, perr_d;

    // Sticky parity error, checked on the word leaving the FIFO
    always_comb begin
        perr_d = perr_q;
        if (bus.clear_err_i) begin
            perr_d = 1'b0;
        end else if (rd_chk && (even_parity(PARITY_MAX_W'(mem_rdata[DATA_WIDTH-1:0])) != mem_rdata[DATA_WIDTH])) begin
            perr_d = 1'b1;
        end
    end

    // Parity error register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.parity_err_o = perr_q;
`else
    logic unused_rd_chk;
    assign unused_rd_chk = rd_chk;
`endif

    assign bus.rd_data_o      = mem_rdata[DATA_WIDTH-1:0];
    assign bus.full_o         = full_q;
    assign bus.empty_o        = empty_q;
    assign bus.almost_full_o  = afull_q;
    assign bus.almost_empty_o = aempty_q;
    assign bus.count_o        = count_q;
    assign bus.overflow_o     = ovf_q;
    assign bus.underflow_o    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Bench for sync_fifo_flagged: an FWFT instance and a registered-read instance
// (DEPTH=8, W=16) share one directed stimulus and are checked every cycle
// against a queue-based model, plus literal spot checks.
module tb_sync_fifo_flagged;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
    logic [W-1:0] wdata = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sync_fifo_flagged_if #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) if_a ();
    sync_fifo_flagged_if #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) if_b ();

    assign if_a.flush_i = flush;     assign if_b.flush_i = flush;
    assign if_a.write_i = wr;        assign if_b.write_i = wr;
    assign if_a.wr_data_i = wdata;   assign if_b.wr_data_i = wdata;
    assign if_a.read_i = rd;         assign if_b.read_i = rd;
    assign if_a.clear_err_i = clr;   assign if_b.clear_err_i = clr;

    sync_fifo_flagged #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1)) u_fwft (
        .clk_i(clk), .rst_n_i(rst_n), .bus(if_a));
    sync_fifo_flagged #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0)) u_reg (
        .clk_i(clk), .rst_n_i(rst_n), .bus(if_b));

    // Model: contents as a queue, sticky errors, last registered read word
    logic [W-1:0] mq[$];
    bit           m_ovf = 0, m_udf = 0, m_rv = 0;
    logic [W-1:0] m_rd = '0;

    always @(posedge clk or negedge rst_n) begin
        int  n;
        bit  acc_rd, acc_wr;
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0;
        end else if (flush) begin
            mq.delete();
            m_rv = 0;
            if (clr) begin m_ovf = 0; m_udf = 0; end
        end else begin
            n      = mq.size();
            acc_rd = rd && (n > 0);
            acc_wr = wr && ((n < D) || acc_rd);
            if (clr) begin
                m_ovf = 0; m_udf = 0;
            end else begin
                if (wr && !acc_wr) m_ovf = 1;
                if (rd && n == 0)  m_udf = 1;
            end
            m_rv = acc_rd;
            if (acc_rd) m_rd = mq.pop_front();
            if (acc_wr) mq.push_back(wdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        int n;
        n = mq.size();
        chk("a.count", 32'(if_a.count_o), 32'(n));
        chk("b.count", 32'(if_b.count_o), 32'(n));
        chk("a.empty", 32'(if_a.empty_o), 32'(n == 0));
        chk("b.empty", 32'(if_b.empty_o), 32'(n == 0));
        chk("a.full", 32'(if_a.full_o), 32'(n == D));
        chk("b.full", 32'(if_b.full_o), 32'(n == D));
        chk("a.afull", 32'(if_a.almost_full_o), 32'(n >= D - 2));
        chk("b.afull", 32'(if_b.almost_full_o), 32'(n >= D - 2));
        chk("a.aempty", 32'(if_a.almost_empty_o), 32'(n <= 2));
        chk("b.aempty", 32'(if_b.almost_empty_o), 32'(n <= 2));
        chk("a.ovf", 32'(if_a.overflow_o), 32'(m_ovf));
        chk("b.ovf", 32'(if_b.overflow_o), 32'(m_ovf));
        chk("a.udf", 32'(if_a.underflow_o), 32'(m_udf));
        chk("b.udf", 32'(if_b.underflow_o), 32'(m_udf));
        chk("a.rd_valid", 32'(if_a.rd_valid_o), 32'(n != 0));
        if (n != 0) chk("a.rd_data", 32'(if_a.rd_data_o), 32'(mq[0]));
        chk("b.rd_valid", 32'(if_b.rd_valid_o), 32'(m_rv));
        chk("b.rd_data", 32'(if_b.rd_data_o), 32'(m_rd));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_in();
        flush = 0; wr = 0; rd = 0; clr = 0;
    endtask

    initial begin
        // Reset, released between clock edges
        idle_in();
        repeat (3) cyc();
        #2 rst_n = 1'b1;
        cyc();
        chk("lit.reset.count", 32'(if_a.count_o), 32'd0);
        chk("lit.reset.empty", 32'(if_b.empty_o), 32'd1);
        chk("lit.reset.b_data", 32'(if_b.rd_data_o), 32'h0);

        // Fill with 1..8, checking almost-full onset at 6 and full at 8
        for (int i = 1; i <= D; i++) begin
            wr = 1; wdata = W'(i);
            cyc();
            if (i == 5) chk("lit.afull_at5", 32'(if_a.almost_full_o), 32'd0);
            if (i == 6) chk("lit.afull_at6", 32'(if_a.almost_full_o), 32'd1);
        end
        wr = 0;
        chk("lit.full", 32'(if_a.full_o), 32'd1);
        chk("lit.count8", 32'(if_b.count_o), 32'd8);

        // Drain in order
        for (int i = 1; i <= D; i++) begin
            chk("lit.fwft_head", 32'(if_a.rd_data_o), 32'(i));
            rd = 1;
            cyc();
            chk("lit.reg_data", 32'(if_b.rd_data_o), 32'(i));
            chk("lit.reg_valid", 32'(if_b.rd_valid_o), 32'd1);
        end
        rd = 0;
        chk("lit.empty_after_drain", 32'(if_a.empty_o), 32'd1);

        // Refill, then overflow attempt, then read+write while full
        for (int i = 1; i <= D; i++) begin
            wr = 1; wdata = W'(i);
            cyc();
        end
        wdata = 16'hDEAD;
        cyc();
        chk("lit.ovf_set", 32'(if_a.overflow_o), 32'd1);
        chk("lit.ovf_count", 32'(if_a.count_o), 32'd8);
        rd = 1;
        chk("lit.head_before_both", 32'(if_a.rd_data_o), 32'h0001);
        cyc();
        wr = 0; rd = 0;
        chk("lit.both_reg_data", 32'(if_b.rd_data_o), 32'h0001);
        chk("lit.both_count", 32'(if_b.count_o), 32'd8);
        chk("lit.both_head", 32'(if_a.rd_data_o), 32'h0002);

        // Down to 5 entries, then flush with a concurrent write
        rd = 1;
        repeat (3) cyc();
        rd = 0;
        chk("lit.count5", 32'(if_a.count_o), 32'd5);
        flush = 1; wr = 1; wdata = 16'hBEEF;
        cyc();
        flush = 0; wr = 0;
        chk("lit.flush_count", 32'(if_a.count_o), 32'd0);
        chk("lit.flush_aempty", 32'(if_a.almost_empty_o), 32'd1);
        chk("lit.flush_ovf_kept", 32'(if_b.overflow_o), 32'd1);
        chk("lit.flush_b_data_held", 32'(if_b.rd_data_o), 32'h0004);

        // Underflow, then clear racing a fresh bad read
        rd = 1;
        cyc();
        chk("lit.udf_set", 32'(if_a.underflow_o), 32'd1);
        clr = 1;
        cyc();
        clr = 0; rd = 0;
        chk("lit.udf_cleared", 32'(if_a.underflow_o), 32'd0);
        chk("lit.ovf_cleared", 32'(if_b.overflow_o), 32'd0);

        // Registered read latency and hold
        wr = 1; wdata = 16'hA5A5;
        cyc();
        wr = 0; rd = 1;
        cyc();
        rd = 0;
        chk("lit.reg_pulse", 32'(if_b.rd_valid_o), 32'd1);
        chk("lit.reg_a5a5", 32'(if_b.rd_data_o), 32'hA5A5);
        cyc();
        chk("lit.reg_pulse_end", 32'(if_b.rd_valid_o), 32'd0);
        chk("lit.reg_a5a5_held", 32'(if_b.rd_data_o), 32'hA5A5);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 4; i++) begin
            wr = 1; wdata = W'(16'h0100 + i);
            cyc();
        end
        #2 rst_n = 1'b0;
        wr = 0;
        #1;
        chk("lit.async_count", 32'(if_a.count_o), 32'd0);
        chk("lit.async_empty", 32'(if_b.empty_o), 32'd1);
        chk("lit.async_b_data", 32'(if_b.rd_data_o), 32'h0);
        chk("lit.async_b_valid", 32'(if_b.rd_valid_o), 32'd0);
        cyc();
        #2 rst_n = 1'b1;
        cyc();

        // Pointer rollover: stream 20 words keeping a few in flight
        for (int k = 0; k < 20; k++) begin
            wr = 1; wdata = W'(16'h0200 + k);
            rd = (k >= 3);
            cyc();
        end
        wr = 0;
        chk("lit.wrap_head", 32'(if_a.rd_data_o), 32'h0211);
        rd = 1;
        repeat (3) cyc();
        rd = 0;
        chk("lit.wrap_last", 32'(if_b.rd_data_o), 32'h0213);
        chk("lit.wrap_empty", 32'(if_a.empty_o), 32'd1);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flagged.md
Name: sync_fifo_flagged

Overview:
Next-generation parametrised synchronous FIFO. A circular-queue buffer with configurable width and depth and selectable FWFT or registered read. Adds an occupancy counter, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush, and read-during-full acceptance. Drop-in buffer for streaming datapaths sharing one clock domain.

Parameters:
DATA_WIDTH, 32, word width in bits (>=1)
FIFO_DEPTH, 32, words stored; power of two, >=4
FWFT, 1, 1 = head word combinationally on rd_data_o; 0 = registered read, data one cycle after accepted read
AF_THRESH, FIFO_DEPTH-2, almost_full_o asserted when count >= AF_THRESH (1..FIFO_DEPTH)
AE_THRESH, 2, almost_empty_o asserted when count <= AE_THRESH (0..FIFO_DEPTH-1)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous flush: empties FIFO, memory contents untouched
write_i  in  1  write request
wr_data_i  in  DATA_WIDTH  write data
read_i  in  1  read request
rd_data_o  out  DATA_WIDTH  read data
rd_valid_o  out  1  FWFT=1: equals !empty_o; FWFT=0: one-cycle pulse with registered data
full_o  out  1  count == FIFO_DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count >= AF_THRESH
almost_empty_o  out  1  count <= AE_THRESH
count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow_o  out  1  sticky: write attempted while full and not accepted
underflow_o  out  1  sticky: read attempted while empty
clear_err_i  in  1  clears overflow_o/underflow_o next edge

Behaviour:
- Reset (async assert, sync release): ptrs=0, count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0, rd_valid_o=0, rd_data_o=0 (FWFT=0).
- Pointers carry an extra wrap bit (ADDR_BITS+1). full = addr equal, wrap bits differ. empty = fully equal.
- rd_en = read_i & !empty_o.
- wr_en = write_i & (!full_o | rd_en): a write on a full FIFO is accepted when a read is accepted in the same cycle.
- On both accepted: both pointers advance; count unchanged; flags unchanged.
- Both requested while empty: only the write is accepted; underflow_o set.
- count_o and all flags are registered and reflect post-edge state, with no combinational path from request to flag.
- Sticky error flags:
  - overflow_o sets on write_i & !wr_en.
  - underflow_o sets on read_i & empty_o.
  - clear_err_i has priority over set in the same cycle.
- flush_i: ptrs and count go to 0 and flags take reset values on the next edge. Requests that cycle are ignored. Error flags are untouched.
- FWFT=1: rd_data_o = mem[rd_ptr] combinationally. Value is undefined when empty.
- FWFT=0: rd_data_o registers mem[rd_ptr] on rd_en, with rd_valid_o pulsed the next cycle. rd_data_o otherwise holds its value.
- Pointer wrap at FIFO_DEPTH-1 -> 0 is natural binary rollover of the address bits.

Optional Feature:
SYNC_FIFO_PARITY_EN
- Defined: each stored word gains an even-parity bit computed on write and checked on read (output side, both modes). Adds port parity_err_o (out, 1): a sticky flag, set on mismatch, cleared by clear_err_i or reset.
- Undefined: no parity storage, no parity_err_o port; memory is DATA_WIDTH wide.

Decomposition:
- Package sync_fifo_pkg:
  - access_mode_t enum {IDLE=2'b00, READ=2'b01, WRITE=2'b10, BOTH=2'b11}
  - function addr_bits(depth) wrapping $clog2
  - parity function
- Sub-module sync_fifo_mem: DATA_WIDTH x FIFO_DEPTH array; write port, read port comb or registered per FWFT. No reset on the array.
- Top holds pointers, counter, flags, error logic.

Test Plan:
1. DEPTH=8, W=16, FWFT=1: write 0x0001..0x0008 -> full_o=1 after 8th edge, count_o=8, almost_full_o from count 6; read 8 -> data 0x0001..0x0008 in order, empty_o=1.
2. Full FIFO, write_i=1 alone with 0xDEAD -> not stored, overflow_o=1, count_o=8. Then write_i+read_i -> head 0x0001 read, 0xDEAD stored, count_o=8.
3. Empty FIFO, read_i=1 -> underflow_o=1, count_o=0. clear_err_i with simultaneous bad read -> flag cleared (clear wins).
4. FWFT=0: write 0xA5A5, read next cycle -> rd_valid_o pulses one cycle after read, rd_data_o=0xA5A5 and held afterwards.
5. Count 5, flush_i=1 with write_i=1 -> count_o=0, empty_o=1, almost_empty_o=1, write dropped, overflow_o unchanged.
6. Assert rst_n_i low mid-burst asynchronously (between edges) -> outputs reach reset values immediately. After release, 20 wrap-around writes/reads show in-order data across pointer rollover.
